// File: rtl/axis_lrelu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axis_lrelu_seq_ctrl
// Purpose  : Config/data sequencer in front of the LReLU engine. Each block
//            starts with a run of config beats, passed straight through to
//            the config port. The beat count comes from a per-mode table
//            indexed by the mode field of the first beat. After a fill wait
//            the data beats are serialized MEMBERS->1 into the engine. When
//            the tlast member has been taken, cfg_clear is pulsed and the
//            sequencer returns to config.
// Ports    : aclk/areset     clock, synchronous active-high reset
//            s_axis_*        input stream from the conv core
//            m_cfg_*         config port (zero-latency passthrough)
//            cfg_clear       config buffer clear pulse
//            m_axis_*        serialized data stream to the engine
//            cfg_err         sticky flag: tlast seen on a config beat
//            state_o         current state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module axis_lrelu_seq_ctrl #(
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned LANES        = 8,
    parameter int unsigned MEMBERS      = 4,
    parameter int unsigned TUSER_WIDTH  = 8,
    parameter int unsigned MODE_BITS    = 2,
    parameter int unsigned I_MODE       = 0,
    parameter logic [8*(2**MODE_BITS)-1:0] CONFIG_BEATS = {8'd21, 8'd9, 8'd4, 8'd1},
    parameter int unsigned CLEAR_CYCLES = 1,
    parameter int unsigned FILL_CYCLES  = 3
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic [MEMBERS*LANES*WORD_WIDTH-1:0]   s_axis_tdata,
    input  logic [TUSER_WIDTH-1:0]                s_axis_tuser,
    input  logic                                  s_axis_tlast,
    output logic                                  m_cfg_tvalid,
    input  logic                                  m_cfg_tready,
    output logic [MEMBERS*LANES*WORD_WIDTH-1:0]   m_cfg_tdata,
    output logic                                  m_cfg_tlast,
    output logic                                  cfg_clear,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [LANES*WORD_WIDTH-1:0]           m_axis_tdata,
    output logic [TUSER_WIDTH-1:0]                m_axis_tuser,
    output logic                                  m_axis_tlast,
    output logic                                  cfg_err,
    output logic [2:0]                            state_o
);

    localparam int unsigned MEMBER_W  = LANES * WORD_WIDTH;
    localparam int unsigned BEAT_W    = MEMBERS * MEMBER_W;
    localparam int unsigned NUM_MODES = 2 ** MODE_BITS;

    // Largest entry of the beat-count table sizes the config counter.
    function automatic int unsigned max_entry();
        int unsigned m;
        m = 1;
        for (int k = 0; k < int'(NUM_MODES); k++) begin
            if (32'(CONFIG_BEATS[8*k +: 8]) > m) begin
                m = 32'(CONFIG_BEATS[8*k +: 8]);
            end
        end
        return m;
    endfunction

    localparam int unsigned MAX_BEATS = max_entry();
    localparam int unsigned CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int unsigned TMR_MAX   = (FILL_CYCLES > CLEAR_CYCLES) ? FILL_CYCLES : CLEAR_CYCLES;
    localparam int unsigned TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
    localparam int unsigned IDX_W     = (MEMBERS > 1) ? $clog2(MEMBERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEMBERS - 1);

    typedef enum logic [2:0] {
        PASS    = 3'd0,
        DRAIN   = 3'd1,
        CLEAR   = 3'd2,
        WRITE_1 = 3'd3,
        WRITE_2 = 3'd4,
        FILL    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic                 err_q, err_d;

    // Serializer storage: one beat plus the index of the member on the output.
    logic                 full_q;
    logic [IDX_W-1:0]     idx_q;
    logic [BEAT_W-1:0]    data_q;
    logic [TUSER_WIDTH-1:0] user_q;
    logic                 last_q;

    logic [MODE_BITS-1:0] w_mode;
    logic [7:0]           w_beats;
    logic                 w_single;
    logic                 w_cfg_hs;
    logic                 w_last_member;
    logic                 w_out_hs;
    logic                 w_pass_ready;
    logic                 w_load;

    assign w_mode        = s_axis_tuser[I_MODE +: MODE_BITS];
    assign w_beats       = CONFIG_BEATS[{w_mode, 3'b000} +: 8];
    // A zero table entry is treated like one so the count never underflows.
    assign w_single      = (w_beats <= 8'd1);
    assign w_cfg_hs      = ((state_q == WRITE_1) || (state_q == WRITE_2))
                           && s_axis_tvalid && m_cfg_tready;
    assign w_last_member = (idx_q == LAST_IDX);
    assign w_out_hs      = full_q && m_axis_tready;
    // Accept while empty, or while the final member leaves this very cycle,
    // so consecutive beats stream without a bubble.
    assign w_pass_ready  = !full_q || (w_last_member && m_axis_tready);
    assign w_load        = (state_q == PASS) && s_axis_tvalid && w_pass_ready;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= WRITE_1;
            cnt_q   <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tmr_d         = tmr_q;
        err_d         = err_q | (w_cfg_hs & s_axis_tlast);
        s_axis_tready = 1'b0;
        m_cfg_tvalid  = 1'b0;
        m_cfg_tlast   = 1'b0;

        case (state_q)
            WRITE_1: begin
                m_cfg_tvalid  = s_axis_tvalid;
                s_axis_tready = m_cfg_tready;
                m_cfg_tlast   = w_single;
                if (w_cfg_hs) begin
                    tmr_d = '0;
                    if (w_single) begin
                        state_d = FILL;
                    end else begin
                        // Remaining beats after the next one; WRITE_2 ends at 0.
                        cnt_d   = CNT_W'(w_beats - 8'd2);
                        state_d = WRITE_2;
                    end
                end
            end
            WRITE_2: begin
                m_cfg_tvalid  = s_axis_tvalid;
                s_axis_tready = m_cfg_tready;
                m_cfg_tlast   = (cnt_q == '0);
                if (w_cfg_hs) begin
                    if (cnt_q == '0) begin
                        tmr_d   = '0;
                        state_d = FILL;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            FILL: begin
                // A zero fill length still spends one cycle here.
                if ((32'(tmr_q) + 32'd1) >= FILL_CYCLES) begin
                    tmr_d   = '0;
                    state_d = PASS;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            PASS: begin
                s_axis_tready = w_pass_ready;
                if (w_load && s_axis_tlast) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_out_hs && m_axis_tlast) begin
                    tmr_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if ((32'(tmr_q) + 32'd1) >= CLEAR_CYCLES) begin
                    tmr_d   = '0;
                    state_d = WRITE_1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = WRITE_1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // MEMBERS->1 serializer
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            full_q <= 1'b0;
            idx_q  <= '0;
        end else if (w_load) begin
            full_q <= 1'b1;
            idx_q  <= '0;
        end else if (w_out_hs) begin
            if (w_last_member) begin
                full_q <= 1'b0;
                idx_q  <= '0;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    // Payload needs no reset: it is only observed while full_q is set.
    always_ff @(posedge aclk) begin
        if (w_load) begin
            data_q <= s_axis_tdata;
            user_q <= s_axis_tuser;
            last_q <= s_axis_tlast;
        end
    end

    logic [MEMBER_W-1:0] w_members [MEMBERS];

    for (genvar m = 0; m < int'(MEMBERS); m++) begin : g_members
        assign w_members[m] = data_q[m*MEMBER_W +: MEMBER_W];
    end

    assign m_axis_tvalid = full_q;
    assign m_axis_tdata  = w_members[idx_q];
    assign m_axis_tuser  = user_q;
    assign m_axis_tlast  = full_q && last_q && w_last_member;

    assign m_cfg_tdata   = s_axis_tdata;
    assign cfg_clear     = (state_q == CLEAR);
    assign cfg_err       = err_q;
    assign state_o       = state_q;

endmodule
`default_nettype wire
